// File: rtl/uart_transmitter_if.sv
// Bus-side write port of the UART transmitter: a byte, a one-cycle request
// pulse and the idle/ready indication back to the requester.
interface uart_transmitter_if;
    logic [7:0] write_data;
    logic       write_req;
    logic       ready;

    // Requester side: offers bytes, watches ready.
    modport master (
        output write_data,
        output write_req,
        input  ready
    );

    // Transmitter side: takes bytes, reports ready.
    modport slave (
        input  write_data,
        input  write_req,
        output ready
    );
endinterface

// File: rtl/uart_transmitter.sv
// UART transmitter: 8 data bits LSB first, no parity, one or two stop bits.
// Each bit lasts CLOCKS_PER_BIT clocks, timed by a down-counter that is
// reloaded at every bit boundary. The serial line is driven from a register.
module uart_transmitter #(
    parameter int CLOCKS_PER_BIT = 868,
    parameter int STOP_BITS      = 1
) (
    input  logic               clk,
    input  logic               reset,
    uart_transmitter_if.slave  bus,
    output logic               tx
);

    localparam int              CNT_W      = $clog2(CLOCKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [2:0]       LAST_DATA  = 3'd7;
    localparam logic [2:0]       LAST_STOP  = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [2:0]       bit_idx_r;
    logic [2:0]       bit_idx_s;
    logic [7:0]       shift_r;
    logic [7:0]       shift_s;
    logic             tx_r;
    logic             tx_s;
    logic             bit_end_s;

    // Ready is a pure decode of the registered state.
    assign bus.ready = (state_r == ST_IDLE);
    assign tx        = tx_r;

    // State, timing and data registers; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
            tx_r      <= 1'b1;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            bit_idx_r <= bit_idx_s;
            shift_r   <= shift_s;
            tx_r      <= tx_s;
        end
    end

    // Next-state logic: bit timing, data shifting and the line value for the next cycle.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        bit_idx_s = bit_idx_r;
        shift_s   = shift_r;
        tx_s      = 1'b1;
        bit_end_s = (cnt_r == CNT_ZERO);

        case (state_r)
            ST_IDLE: begin
                if (bus.write_req) begin
                    // Byte is captured here only; later bus changes are not seen.
                    state_s   = ST_START;
                    cnt_s     = CNT_RELOAD;
                    bit_idx_s = 3'd0;
                    shift_s   = bus.write_data;
                end else begin
                    cnt_s     = CNT_ZERO;
                    bit_idx_s = 3'd0;
                end
            end

            ST_START: begin
                if (bit_end_s) begin
                    state_s = ST_DATA;
                    cnt_s   = CNT_RELOAD;
                end else begin
                    cnt_s   = cnt_r - CNT_ONE;
                end
            end

            ST_DATA: begin
                if (bit_end_s) begin
                    cnt_s = CNT_RELOAD;
                    if (bit_idx_r == LAST_DATA) begin
                        // Index is reused to count stop bits.
                        state_s   = ST_STOP;
                        bit_idx_s = 3'd0;
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                        shift_s   = {1'b0, shift_r[7:1]};
                    end
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end

            ST_STOP: begin
                if (bit_end_s) begin
                    if (bit_idx_r == LAST_STOP) begin
                        state_s   = ST_IDLE;
                        cnt_s     = CNT_ZERO;
                        bit_idx_s = 3'd0;
                    end else begin
                        cnt_s     = CNT_RELOAD;
                        bit_idx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end

            default: begin
                state_s   = ST_IDLE;
                cnt_s     = CNT_ZERO;
                bit_idx_s = 3'd0;
                shift_s   = 8'd0;
            end
        endcase

        // Line value follows the state being entered, so tx stays registered.
        case (state_s)
            ST_IDLE:  tx_s = 1'b1;
            ST_START: tx_s = 1'b0;
            ST_DATA:  tx_s = shift_s[0];
            ST_STOP:  tx_s = 1'b1;
            default:  tx_s = 1'b1;
        endcase
    end

endmodule
